// File: rtl/bldcm_ramp_ctrl.sv
// bldcm_ramp_ctrl: steps the motor block's frequency target toward a commanded value, polling status after every write
module bldcm_ramp_ctrl #(
  parameter logic [31:0] pStepHz     = 32'd100,
  parameter logic [31:0] pStepCycles = 32'd50000,
  parameter logic [15:0] pPollLimit  = 16'd1024,
  parameter logic [1:0]  pAddrFreq   = 2'd0,
  parameter logic [1:0]  pAddrStatus = 2'd1
) (
  input  logic        iClock,
  input  logic        iReset_n,
  input  logic        iCmdValid,
  output logic        oCmdReady,
  input  logic [31:0] iCmdFreq,
  input  logic        iAbort,
  output logic        oBusy,
  output logic        oDone,
  output logic        oErr,
  output logic [31:0] oCurFreq,
  output logic [1:0]  oAddr,
  output logic        oRead,
  input  logic [31:0] iRdata,
  output logic        oWrite,
  output logic [31:0] oWdata,
  input  logic [1:0]  iResp
);
  typedef enum logic [2:0] {IDLE, CALC, WRITE, POLL_RD, POLL_WT, WAIT} state_t;
  state_t state_q, state_d;
  logic [31:0] cur_q, cur_d, tgt_q, tgt_d, next_q, next_d, cnt_q, cnt_d, wdata_q, wdata_d;
  logic [15:0] poll_q, poll_d;
  logic [1:0] addr_q, addr_d;
  logic write_q, write_d, read_q, read_d, done_q, done_d, err_q, err_d, busy_q, busy_d;
  logic [31:0] tgt_n, cmd_tgt, step_val;
  logic [32:0] up_sum;
  logic accept;
  logic unused_rdata;
  assign unused_rdata = ^iRdata[31:1];
  always_comb begin
    tgt_n    = iAbort ? 32'd0 : tgt_q;
    cmd_tgt  = iAbort ? 32'd0 : iCmdFreq;
    accept   = iCmdValid && !busy_q;
    // 33-bit sum so a step near the top of the range saturates instead of wrapping
    up_sum   = {1'b0, cur_q} + {1'b0, pStepHz};
    step_val = cur_q < tgt_n ? (up_sum > {1'b0, tgt_n} ? tgt_n : up_sum[31:0])
                             : (cur_q - tgt_n > pStepHz ? cur_q - pStepHz : tgt_n);
    state_d  = state_q;
    cur_d    = cur_q;
    tgt_d    = tgt_n;
    next_d   = next_q;
    cnt_d    = cnt_q;
    poll_d   = poll_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    write_d  = 1'b0;
    read_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          tgt_d = cmd_tgt;
          err_d = 1'b0;
          if (cmd_tgt == cur_q) done_d = 1'b1;
          else state_d = CALC;
        end else if (iAbort && cur_q != 32'd0) begin
          state_d = CALC;
        end
      end
      CALC: begin
        next_d  = step_val;
        wdata_d = step_val;
        addr_d  = pAddrFreq;
        write_d = 1'b1;
        poll_d  = 16'd0;
        state_d = WRITE;
      end
      WRITE: begin
        addr_d  = pAddrStatus;
        read_d  = 1'b1;
        state_d = POLL_RD;
      end
      POLL_RD: begin
        poll_d  = poll_q + 16'd1;
        state_d = POLL_WT;
      end
      POLL_WT: begin
        if (iResp != 2'b00) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (iRdata[0]) begin
          cur_d = next_q;
          if (next_q == tgt_n) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else if (pStepCycles < 32'd2) begin
            state_d = CALC;
          end else begin
            // CALC supplies the last cycle of the inter-step gap
            cnt_d   = pStepCycles - 32'd2;
            state_d = WAIT;
          end
        end else if (poll_q < pPollLimit) begin
          addr_d  = pAddrStatus;
          read_d  = 1'b1;
          state_d = POLL_RD;
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (iAbort || cnt_q == 32'd0) state_d = CALC;
        else cnt_d = cnt_q - 32'd1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q <= IDLE;
      cur_q   <= '0;
      tgt_q   <= '0;
      next_q  <= '0;
      cnt_q   <= '0;
      poll_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      read_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      next_q  <= next_d;
      cnt_q   <= cnt_d;
      poll_q  <= poll_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      read_q  <= read_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end
  assign oCmdReady = !busy_q;
  assign oBusy     = busy_q;
  assign oDone     = done_q;
  assign oErr      = err_q;
  assign oCurFreq  = cur_q;
  assign oAddr     = addr_q;
  assign oRead     = read_q;
  assign oWrite    = write_q;
  assign oWdata    = wdata_q;
endmodule

// File: tb/tb_bldcm_ramp_ctrl.sv
// tb_bldcm_ramp_ctrl: directed ramps against a step-list model and a status-word responder
module tb_bldcm_ramp_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic cmd_valid = 1'b0, abort = 1'b0;
  logic [31:0] cmd_freq = 32'd0;
  logic [31:0] rdata = 32'd0;
  logic [1:0] resp = 2'b00;
  logic cmd_ready, busy, done, err, rd, wr;
  logic [31:0] cur_freq, wdata;
  logic [1:0] addr;
  logic s_valid = 1'b0;
  logic [31:0] s_freq = 32'd0, s_rdata = 32'd0;
  logic s_ready, s_busy, s_done, s_err, s_rd, s_wr;
  logic [31:0] s_cur, s_wdata;
  logic [1:0] s_addr;

  bldcm_ramp_ctrl #(.pStepHz(32'd100), .pStepCycles(32'd4), .pPollLimit(16'd4)) dut (
    .iClock(clk), .iReset_n(rst_n), .iCmdValid(cmd_valid), .oCmdReady(cmd_ready),
    .iCmdFreq(cmd_freq), .iAbort(abort), .oBusy(busy), .oDone(done), .oErr(err),
    .oCurFreq(cur_freq), .oAddr(addr), .oRead(rd), .iRdata(rdata), .oWrite(wr),
    .oWdata(wdata), .iResp(resp));

  bldcm_ramp_ctrl #(.pStepHz(32'h8000_0000), .pStepCycles(32'd2), .pPollLimit(16'd4)) dut_sat (
    .iClock(clk), .iReset_n(rst_n), .iCmdValid(s_valid), .oCmdReady(s_ready),
    .iCmdFreq(s_freq), .iAbort(1'b0), .oBusy(s_busy), .oDone(s_done), .oErr(s_err),
    .oCurFreq(s_cur), .oAddr(s_addr), .oRead(s_rd), .iRdata(s_rdata), .oWrite(s_wr),
    .oWdata(s_wdata), .iResp(2'b00));

  int checks = 0, fails = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [31:0] exp_q[$];
  logic [31:0] s_log[$];
  logic [31:0] cur_m = 32'd0, tgt_m = 32'd0, last_wr = 32'd0;
  int cyc = 0, acc_cyc = 0, last_wr_cyc = 0, reads_step = 0, reads_total = 0;
  int writes_seen = 0, done_cnt = 0, reads_needed = 1, rd_in_step = 0, s_done_cnt = 0;
  bit stuck = 1'b0, err_mode = 1'b0, first_pending = 1'b0, skip_spacing = 1'b0, ack_pend = 1'b0;

  // Expected write values: step by 100 toward the target, clamping at the target
  function automatic void push_ramp(input logic [31:0] from, input logic [31:0] to);
    longint c = from;
    longint t = to;
    while (c != t) begin
      c = (c < t) ? ((c + 100 > t) ? t : c + 100) : ((c - t > 100) ? c - 100 : t);
      exp_q.push_back(32'(c));
    end
  endfunction

  // Motor-block status responder; a reflected OK read makes the last written value current
  always @(posedge clk) begin
    if (!rst_n) begin
      cur_m <= 32'd0; rdata <= 32'd0; resp <= 2'b00; ack_pend <= 1'b0; rd_in_step <= 0;
    end else begin
      if (ack_pend && resp == 2'b00 && rdata[0]) cur_m <= last_wr;
      ack_pend <= rd;
      rdata <= {16'hA5A5, 15'h0, rd && !stuck && (rd_in_step + 1 >= reads_needed)};
      resp <= (rd && err_mode) ? 2'b10 : 2'b00;
      rd_in_step <= wr ? 0 : rd ? rd_in_step + 1 : rd_in_step;
    end
  end
  always @(posedge clk) s_rdata <= {31'h0, s_rd};

  always @(posedge clk) begin
    if (rst_n && cmd_valid && cmd_ready) acc_cyc <= cyc;
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("ready_is_not_busy", 32'(cmd_ready), 32'(!busy));
      chk("cur_freq", cur_freq, cur_m);
      chk("rd_wr_exclusive", 32'(rd & wr), 0);
      if (wr) begin
        chk("wr_addr", 32'(addr), 0);
        if (exp_q.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_write: got %0h expected none", wdata);
        end else chk("wr_data", wdata, exp_q.pop_front());
        if (first_pending) chk("first_wr_latency", cyc - acc_cyc, 2);
        else if (!skip_spacing) begin
          chk("wr_spacing", cyc - last_wr_cyc, 7 + 2 * (reads_needed - 1));
          chk("reads_per_step", reads_step, reads_needed);
        end
        first_pending = 1'b0; skip_spacing = 1'b0; last_wr = wdata;
        last_wr_cyc = cyc; reads_step = 0; writes_seen++;
      end
      if (rd) begin
        chk("rd_addr", 32'(addr), 1);
        reads_step++; reads_total++;
      end
      if (done) begin
        done_cnt++;
        chk("done_no_pending", exp_q.size(), 0);
        chk("done_cur_eq_tgt", cur_freq, tgt_m);
        if (!first_pending) chk("reads_last_step", reads_step, reads_needed);
      end
      if (s_wr) begin
        chk("sat_wr_addr", 32'(s_addr), 0);
        s_log.push_back(s_wdata);
      end
      if (s_done) s_done_cnt++;
    end
  end

  task automatic cmd(input logic [31:0] f, input bit ab);
    tgt_m = ab ? 32'd0 : f;
    exp_q.delete();
    push_ramp(cur_m, tgt_m);
    first_pending = 1'b1;
    @(negedge clk); cmd_valid = 1'b1; cmd_freq = f; abort = ab;
    @(negedge clk); cmd_valid = 1'b0; abort = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 300) begin @(negedge clk); n++; end
    if (busy) begin checks++; fails++; $display("FAIL %s_timeout: busy 1 expected 0", name); end
    @(negedge clk);
  endtask

  task automatic s_cmd(input logic [31:0] f);
    int n = 0;
    @(negedge clk); s_valid = 1'b1; s_freq = f;
    @(negedge clk); s_valid = 1'b0;
    while (s_busy && n < 100) begin @(negedge clk); n++; end
    if (s_busy) begin checks++; fails++; $display("FAIL sat_timeout: busy 1 expected 0"); end
    @(negedge clk);
  endtask

  int d0, w0, r0, n;
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_cur", cur_freq, 0);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_strobes", 32'({rd, wr}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    s_cmd(32'hFFFF_FF00);
    s_cmd(32'hFFFF_FFF0);
    chk("sat_writes", s_log.size(), 3);
    if (s_log.size() == 3) begin
      chk("sat_wr0", s_log[0], 32'h8000_0000);
      chk("sat_wr1", s_log[1], 32'hFFFF_FF00);
      chk("sat_wr2", s_log[2], 32'hFFFF_FFF0);
    end
    chk("sat_cur", s_cur, 32'hFFFF_FFF0);
    chk("sat_done", s_done_cnt, 2);
    chk("sat_err", 32'(s_err), 0);

    d0 = done_cnt; w0 = writes_seen;
    cmd(32'd300, 1'b1);
    @(negedge clk);
    chk("abort_accept_done", done_cnt - d0, 1);
    chk("abort_accept_writes", writes_seen - w0, 0);

    d0 = done_cnt; w0 = writes_seen;
    cmd(32'd300, 1'b0); wait_idle("up300");
    chk("up300_cur", cur_freq, 32'd300);
    chk("up300_writes", writes_seen - w0, 3);
    chk("up300_done", done_cnt - d0, 1);

    d0 = done_cnt; w0 = writes_seen;
    cmd(32'd50, 1'b0); wait_idle("down50");
    chk("down50_cur", cur_freq, 32'd50);
    chk("down50_writes", writes_seen - w0, 3);
    chk("down50_done", done_cnt - d0, 1);

    d0 = done_cnt; w0 = writes_seen;
    cmd(32'd50, 1'b0);
    @(negedge clk);
    chk("same_done", done_cnt - d0, 1);
    chk("same_writes", writes_seen - w0, 0);
    chk("same_busy", 32'(busy), 0);

    cmd(32'd0, 1'b0); wait_idle("to0");
    reads_needed = 3;
    w0 = writes_seen; r0 = reads_total;
    cmd(32'd250, 1'b0); wait_idle("up250");
    chk("up250_cur", cur_freq, 32'd250);
    chk("up250_writes", writes_seen - w0, 3);
    chk("up250_reads", reads_total - r0, 9);
    reads_needed = 1;

    cmd(32'd0, 1'b0); wait_idle("down0");
    d0 = done_cnt; w0 = writes_seen;
    cmd(32'd1000, 1'b0);
    n = 0;
    while (cur_m != 32'd200 && n < 100) begin @(negedge clk); n++; end
    if (cur_m != 32'd200) begin checks++; fails++; $display("FAIL abort_reach200: got %0h expected c8", cur_m); end
    abort = 1'b1; skip_spacing = 1'b1; tgt_m = 32'd0;
    exp_q.delete(); push_ramp(32'd200, 32'd0);
    @(negedge clk); abort = 1'b0;
    wait_idle("abort");
    chk("abort_cur", cur_freq, 0);
    chk("abort_writes", writes_seen - w0, 4);
    chk("abort_done", done_cnt - d0, 1);

    stuck = 1'b1;
    d0 = done_cnt; w0 = writes_seen;
    cmd(32'd500, 1'b0); wait_idle("stuck");
    chk("stuck_err", 32'(err), 1);
    chk("stuck_reads", reads_step, 4);
    chk("stuck_writes", writes_seen - w0, 1);
    chk("stuck_cur", cur_freq, 0);
    chk("stuck_done", done_cnt - d0, 0);
    stuck = 1'b0;

    cmd(32'd100, 1'b0);
    chk("err_cleared", 32'(err), 0);
    wait_idle("recover");
    chk("recover_cur", cur_freq, 32'd100);

    err_mode = 1'b1;
    cmd(32'd300, 1'b0); wait_idle("resp_err");
    chk("resp_err", 32'(err), 1);
    chk("resp_err_cur", cur_freq, 32'd100);
    err_mode = 1'b0;

    stuck = 1'b1;
    cmd(32'd400, 1'b0);
    n = 0;
    while (!rd && n < 20) begin @(negedge clk); n++; end
    chk("midpoll_reached", 32'(rd), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_read", 32'(rd), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_ready", 32'(cmd_ready), 1);
    chk("arst_cur", cur_freq, 0);
    chk("arst_addr", 32'(addr), 0);
    chk("arst_wdata", wdata, 0);
    chk("arst_err_done", 32'({err, done}), 0);
    exp_q.delete(); tgt_m = 32'd0; stuck = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_cur", cur_freq, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
